// File: rtl/priority_collector.sv
// Priority collector: reassembles the one-hot grants of one priority-encoder scan
// into a channel mask, a grant count and the first error seen during that scan.
module priority_collector #(
   parameter int CH_N    = 16,
   parameter int TIMEOUT = 64
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            arm_i,
   input  logic [CH_N-1:0] ch_sel_i,
   input  logic            zero_i,
   input  logic            cycle_done_i,
   output logic [CH_N-1:0] mask_o,
   output logic [4:0]      count_o,
   output logic            valid_o,
   output logic            busy_o,
   output logic            err_o,
   output logic [1:0]      err_code_o
);
   localparam int IW = (CH_N > 1) ? $clog2(CH_N) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [4:0]    CNT_MAX  = 5'(CH_N);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COLLECT, S_DONE} state_e;
   typedef enum logic [1:0] {
      E_NONE = 2'b00, E_ONEHOT = 2'b01, E_ORDER = 2'b10, E_TIMEOUT = 2'b11
   } err_e;

   state_e          state_q, state_d;
   logic [CH_N-1:0] acc_mask_q, acc_mask_d;
   logic [4:0]      acc_cnt_q, acc_cnt_d;
   logic [IW-1:0]   last_idx_q, last_idx_d;
   logic            have_idx_q, have_idx_d;
   err_e            acc_err_q, acc_err_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [CH_N-1:0] mask_q, mask_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [1:0]      code_q, code_d;

   logic [IW-1:0]   sel_idx;
   logic [CH_N-1:0] p_mask;
   logic [4:0]      p_cnt;
   logic [IW-1:0]   p_idx;
   logic            p_have;
   err_e            p_err;

   // zero_i is informational only: a scan ends on cycle_done_i or timeout.
   logic unused_zero;
   assign unused_zero = zero_i;

   always_comb begin
      sel_idx = '0;
      for (int unsigned i = 0; i < CH_N; i++) begin
         if (ch_sel_i[i]) sel_idx = IW'(i);
      end
   end

   // Scan accumulators as they would be after accepting this cycle's ch_sel_i.
   always_comb begin
      p_mask = acc_mask_q;
      p_cnt  = acc_cnt_q;
      p_idx  = last_idx_q;
      p_have = have_idx_q;
      p_err  = acc_err_q;
      if (ch_sel_i != '0) begin
         if (!$onehot(ch_sel_i)) begin
            if (acc_err_q == E_NONE) p_err = E_ONEHOT;
         end else begin
            if (have_idx_q && (sel_idx <= last_idx_q) && (acc_err_q == E_NONE))
               p_err = E_ORDER;
            p_mask = acc_mask_q | ch_sel_i;
            if (acc_cnt_q < CNT_MAX) p_cnt = acc_cnt_q + 5'd1;
            p_idx  = sel_idx;
            p_have = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_mask_d = acc_mask_q;
      acc_cnt_d  = acc_cnt_q;
      last_idx_d = last_idx_q;
      have_idx_d = have_idx_q;
      acc_err_d  = acc_err_q;
      tmo_d      = tmo_q;
      mask_d     = mask_q;
      cnt_d      = cnt_q;
      code_d     = code_q;
      case (state_q)
         S_IDLE: begin
            if (arm_i) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (!arm_i) begin
               state_d = S_IDLE;
            end else if (ch_sel_i != '0) begin
               state_d    = S_COLLECT;
               acc_mask_d = p_mask;
               acc_cnt_d  = p_cnt;
               last_idx_d = p_idx;
               have_idx_d = p_have;
               acc_err_d  = p_err;
               tmo_d      = '0;
            end else if (cycle_done_i) begin
               state_d = S_DONE;
               mask_d  = acc_mask_q;
               cnt_d   = acc_cnt_q;
               code_d  = acc_err_q;
            end
         end
         S_COLLECT: begin
            acc_mask_d = p_mask;
            acc_cnt_d  = p_cnt;
            last_idx_d = p_idx;
            have_idx_d = p_have;
            acc_err_d  = p_err;
            tmo_d      = tmo_q + TW'(1);
            if (cycle_done_i || (tmo_q == TMO_LAST)) begin
               state_d = S_DONE;
               mask_d  = p_mask;
               cnt_d   = p_cnt;
               code_d  = (!cycle_done_i && (p_err == E_NONE)) ? E_TIMEOUT : p_err;
            end
         end
         S_DONE: begin
            acc_mask_d = '0;
            acc_cnt_d  = '0;
            last_idx_d = '0;
            have_idx_d = 1'b0;
            acc_err_d  = E_NONE;
            tmo_d      = '0;
            state_d    = arm_i ? S_ARMED : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         acc_mask_q <= '0;
         acc_cnt_q  <= '0;
         last_idx_q <= '0;
         have_idx_q <= 1'b0;
         acc_err_q  <= E_NONE;
         tmo_q      <= '0;
         mask_q     <= '0;
         cnt_q      <= '0;
         code_q     <= '0;
      end else begin
         state_q    <= state_d;
         acc_mask_q <= acc_mask_d;
         acc_cnt_q  <= acc_cnt_d;
         last_idx_q <= last_idx_d;
         have_idx_q <= have_idx_d;
         acc_err_q  <= acc_err_d;
         tmo_q      <= tmo_d;
         mask_q     <= mask_d;
         cnt_q      <= cnt_d;
         code_q     <= code_d;
      end
   end

   assign mask_o     = mask_q;
   assign count_o    = cnt_q;
   assign err_code_o = code_q;
   assign err_o      = (code_q != 2'b00);
   assign valid_o    = (state_q == S_DONE);
   assign busy_o     = (state_q == S_COLLECT);

endmodule

// File: tb/tb_priority_collector.sv
// Randomized and directed bench for priority_collector; each scan's expected result
// is derived from the list of grants driven during that scan.
module tb_priority_collector;
   localparam int CH = 16;
   localparam int TO = 24;

   logic          clk = 1'b0;
   logic          reset, arm, zero, done;
   logic [CH-1:0] sel;
   logic [CH-1:0] mask_o;
   logic [4:0]    count_o;
   logic          valid_o, busy_o, err_o;
   logic [1:0]    err_code_o;

   int unsigned n_pass = 0;
   int unsigned n_tot  = 0;

   logic [CH-1:0] stim_sel[$];
   bit            stim_done[$];
   logic [CH-1:0] grants[$];
   logic [CH-1:0] exp_mask;
   logic [4:0]    exp_cnt;
   logic [1:0]    exp_code;

   priority_collector #(.CH_N(CH), .TIMEOUT(TO)) dut (
      .clk_i(clk), .reset_i(reset), .arm_i(arm), .ch_sel_i(sel), .zero_i(zero),
      .cycle_done_i(done), .mask_o(mask_o), .count_o(count_o), .valid_o(valid_o),
      .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [CH-1:0] w, input bit d);
      stim_sel.push_back(w);
      stim_done.push_back(d);
   endtask

   // Reference: OR of one-hot grants, saturating count, first error wins
   // (non-one-hot word, then a one-hot index not above the previous one, then timeout).
   function automatic void model_scan(input bit tmo);
      int last = -1;
      int n = 0;
      exp_mask = '0;
      exp_code = 2'b00;
      foreach (grants[k]) begin
         if ($countones(grants[k]) != 1) begin
            if (exp_code == 2'b00) exp_code = 2'b01;
         end else begin
            int idx = 0;
            for (int b = 0; b < CH; b++) if (grants[k][b]) idx = b;
            if (idx <= last && exp_code == 2'b00) exp_code = 2'b10;
            last = idx;
            exp_mask |= grants[k];
            n++;
         end
      end
      if (tmo && exp_code == 2'b00) exp_code = 2'b11;
      exp_cnt = 5'((n > CH) ? CH : n);
   endfunction

   task automatic run_scan(input string nm);
      grants.delete();
      arm = 1'b1; sel = '0; done = 1'b0; zero = 1'b1;
      step();
      for (int k = 0; k < stim_sel.size(); k++) begin
         sel  = stim_sel[k];
         done = stim_done[k];
         zero = (sel == '0);
         if (k > 0) arm = 1'($urandom_range(0, 1));
         if (sel != '0) grants.push_back(sel);
         step();
         if (k < stim_sel.size() - 1) begin
            n_tot++;
            if (valid_o !== 1'b0 || busy_o !== 1'b1)
               $display("FAIL %s_mid cyc %0d: valid=%b busy=%b, want valid=0 busy=1",
                        nm, k, valid_o, busy_o);
            else n_pass++;
         end
      end
      model_scan(1'b0);
      sel = '0; done = 1'b0; zero = 1'b1;
      n_tot++;
      if (valid_o !== 1'b1 || busy_o !== 1'b0)
         $display("FAIL %s_valid: valid=%b busy=%b, want valid=1 busy=0", nm, valid_o, busy_o);
      else n_pass++;
      n_tot++;
      if (mask_o !== exp_mask) $display("FAIL %s_mask: got %h want %h", nm, mask_o, exp_mask);
      else n_pass++;
      n_tot++;
      if (count_o !== exp_cnt) $display("FAIL %s_count: got %0d want %0d", nm, count_o, exp_cnt);
      else n_pass++;
      n_tot++;
      if (err_code_o !== exp_code || err_o !== (exp_code != 2'b00))
         $display("FAIL %s_err: got code=%b err=%b want code=%b", nm, err_code_o, err_o, exp_code);
      else n_pass++;
      arm = 1'($urandom_range(0, 1));
      step();
      n_tot++;
      if (valid_o !== 1'b0 || mask_o !== exp_mask || count_o !== exp_cnt || err_code_o !== exp_code)
         $display("FAIL %s_hold: valid=%b mask=%h count=%0d code=%b want valid=0 mask=%h count=%0d code=%b",
                  nm, valid_o, mask_o, count_o, err_code_o, exp_mask, exp_cnt, exp_code);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1; arm = 1'b1; sel = '1; done = 1'b1; zero = 1'b0;
      step(); step();
      n_tot++;
      if (mask_o !== '0 || count_o !== 5'd0 || valid_o !== 1'b0 || busy_o !== 1'b0 ||
          err_o !== 1'b0 || err_code_o !== 2'b00)
         $display("FAIL reset: mask=%h count=%0d valid=%b busy=%b err=%b code=%b want all 0",
                  mask_o, count_o, valid_o, busy_o, err_o, err_code_o);
      else n_pass++;
      reset = 1'b0; arm = 1'b0; sel = '0; done = 1'b0;
      step();
   endtask

   task automatic test_ascending();
      stim_sel.delete(); stim_done.delete();
      add(16'h0008, 0); add(16'h0080, 0); add(16'h0800, 0); add(16'h0000, 1);
      run_scan("asc");
      n_tot++;
      if (mask_o !== 16'h0888 || count_o !== 5'd3 || err_o !== 1'b0)
         $display("FAIL asc_const: mask=%h count=%0d err=%b want 0888/3/0", mask_o, count_o, err_o);
      else n_pass++;
   endtask

   task automatic test_empty();
      stim_sel.delete(); stim_done.delete();
      add(16'h0000, 1);
      run_scan("empty");
      n_tot++;
      if (mask_o !== 16'h0000 || count_o !== 5'd0 || err_code_o !== 2'b00)
         $display("FAIL empty_const: mask=%h count=%0d code=%b want 0000/0/00", mask_o, count_o, err_code_o);
      else n_pass++;
   endtask

   task automatic test_order();
      stim_sel.delete(); stim_done.delete();
      add(16'h0010, 0); add(16'h0004, 1);
      run_scan("order");
      n_tot++;
      if (mask_o !== 16'h0014 || count_o !== 5'd2 || err_code_o !== 2'b10)
         $display("FAIL order_const: mask=%h count=%0d code=%b want 0014/2/10", mask_o, count_o, err_code_o);
      else n_pass++;
   endtask

   task automatic test_onehot();
      stim_sel.delete(); stim_done.delete();
      add(16'h8001, 0); add(16'h0002, 0); add(16'h0001, 0); add(16'h0000, 1);
      run_scan("onehot");
      n_tot++;
      if (mask_o !== 16'h0003 || count_o !== 5'd2 || err_code_o !== 2'b01)
         $display("FAIL onehot_const: mask=%h count=%0d code=%b want 0003/2/01", mask_o, count_o, err_code_o);
      else n_pass++;
   endtask

   task automatic test_saturate();
      logic [CH-1:0] w;
      stim_sel.delete(); stim_done.delete();
      for (int b = 0; b < CH; b++) begin
         w = '0; w[b] = 1'b1;
         add(w, 0);
      end
      add(16'h8000, 0); add(16'h0001, 1);
      run_scan("sat");
      n_tot++;
      if (mask_o !== 16'hFFFF || count_o !== 5'd16 || err_code_o !== 2'b10)
         $display("FAIL sat_const: mask=%h count=%0d code=%b want FFFF/16/10", mask_o, count_o, err_code_o);
      else n_pass++;
   endtask

   task automatic test_arm_drop();
      arm = 1'b1; sel = '0; done = 1'b0;
      step();
      arm = 1'b0; sel = 16'h0001;
      step();
      sel = 16'h0002; done = 1'b1;
      step();
      n_tot++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0)
         $display("FAIL arm_drop: busy=%b valid=%b want 0/0", busy_o, valid_o);
      else n_pass++;
      sel = '0; done = 1'b0;
      step();
      n_tot++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0)
         $display("FAIL arm_idle: busy=%b valid=%b want 0/0", busy_o, valid_o);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int cyc = 0;
      arm = 1'b1; sel = '0; done = 1'b0;
      step();
      grants.delete();
      sel = 16'h0001; grants.push_back(sel);
      step();
      sel = '0; arm = 1'b0; zero = 1'b1;
      for (int i = 1; i <= TO + 4; i++) begin
         step();
         if (valid_o === 1'b1) begin cyc = i; break; end
      end
      model_scan(1'b1);
      n_tot++;
      if (cyc != TO) $display("FAIL tmo_latency: valid after %0d cycles want %0d", cyc, TO);
      else n_pass++;
      n_tot++;
      if (mask_o !== exp_mask || count_o !== exp_cnt || err_code_o !== exp_code || err_o !== 1'b1)
         $display("FAIL tmo_result: mask=%h count=%0d code=%b err=%b want %h/%0d/%b/1",
                  mask_o, count_o, err_code_o, err_o, exp_mask, exp_cnt, exp_code);
      else n_pass++;
      zero = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      arm = 1'b1; sel = '0; done = 1'b0;
      step();
      sel = 16'h0001; step();
      sel = 16'h0002; step();
      n_tot++;
      if (busy_o !== 1'b1) $display("FAIL rmid_busy: got %b want 1", busy_o);
      else n_pass++;
      reset = 1'b1; sel = '0;
      step();
      n_tot++;
      if (mask_o !== '0 || count_o !== 5'd0 || valid_o !== 1'b0 || busy_o !== 1'b0 ||
          err_o !== 1'b0 || err_code_o !== 2'b00)
         $display("FAIL rmid_clear: mask=%h count=%0d valid=%b busy=%b err=%b code=%b want all 0",
                  mask_o, count_o, valid_o, busy_o, err_o, err_code_o);
      else n_pass++;
      reset = 1'b0; done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         done = 1'b0;
         if (valid_o === 1'b1) seen = 1'b1;
      end
      n_tot++;
      if (seen) $display("FAIL rmid_novalid: valid pulse seen=1 want 0");
      else n_pass++;
      stim_sel.delete(); stim_done.delete();
      add(16'h0001, 0); add(16'h0000, 1);
      run_scan("after_reset");
   endtask

   task automatic test_random();
      for (int s = 0; s < 40; s++) begin
         int n;
         logic [CH-1:0] w;
         stim_sel.delete(); stim_done.delete();
         if ($urandom_range(0, 7) == 0) begin
            add('0, 1);
         end else begin
            int last = -1;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
               int kind = $urandom_range(0, 9);
               int b;
               if (i == 0 && kind == 9) kind = 0;
               if (kind < 6) begin
                  b = last + 1 + $urandom_range(0, 2);
                  if (b >= CH) b = $urandom_range(0, CH - 1);
                  w = '0; w[b] = 1'b1; last = b;
               end else if (kind < 8) begin
                  b = $urandom_range(0, CH - 1);
                  w = '0; w[b] = 1'b1; last = b;
               end else if (kind == 8) begin
                  w = CH'($urandom);
                  if ($countones(w) < 2) w = 16'h0300;
               end else begin
                  w = '0;
               end
               add(w, (i == n - 1) && (i > 0) && ($urandom_range(0, 1) == 1));
            end
            if (!stim_done[stim_done.size() - 1]) add('0, 1);
         end
         run_scan($sformatf("rand%0d", s));
      end
   endtask

   initial begin
      test_reset();
      test_ascending();
      test_empty();
      test_order();
      test_onehot();
      test_saturate();
      test_arm_drop();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
